// File: rtl/booth_mul8_seq.sv
// booth_mul8_seq: sequential signed 8x8->16 radix-2 Booth multiplier.
// One add/subtract-and-shift step per clock through a single shared A_S_RCA8.

// A_S_RCA8: 8-bit ripple-carry add/subtract (cin=0 add, cin=1 subtract).
module A_S_RCA8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] bx;
  logic       carry;

  // Ripple the carry bit by bit; b is inverted for subtraction.
  always_comb begin
    bx    = b ^ {8{cin}};
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ bx[i] ^ carry;
      carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    cout = carry;
  end

endmodule

module booth_mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [W-1:0]  m_reg;
  logic [W-1:0]  acc;
  logic [W-1:0]  q_reg;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic          sub;
  logic          step_en;
  logic [W-1:0]  sum;
  logic          unused_cout;
  logic          ovf;
  logic          sgn;
  logic [W-1:0]  t;

  // Booth recoding: 10 subtracts M, 01 adds M, 00/11 shift only.
  assign sub     = q_reg[0] & ~q_m1;
  assign step_en = q_reg[0] ^ q_m1;

  A_S_RCA8 u_rca (
    .a    (acc),
    .b    (m_reg),
    .cin  (sub),
    .sum  (sum),
    .cout (unused_cout)
  );

  // True sign of the add/subtract result so M = -128 shifts correctly.
  always_comb begin
    ovf = (acc[W-1] == (m_reg[W-1] ^ sub)) && (sum[W-1] != acc[W-1]);
    if (step_en) begin
      t   = sum;
      sgn = sum[W-1] ^ ovf;
    end else begin
      t   = acc;
      sgn = acc[W-1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (cnt == CW'(7)) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture and one Booth arithmetic-shift step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= '0;
      acc   <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          acc   <= {sgn, t[W-1:1]};
          q_reg <= {t[0], q_reg[W-1:1]};
          q_m1  <= q_reg[0];
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status flags track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == S_RUN);
      done <= (next_state == S_DONE);
    end
  end

  assign product = {acc, q_reg};

endmodule
